// File: rtl/nx_msg_router_if.sv
`default_nettype none
// ============================================================================
//  Module      : nx_msg_router_if
//  Description : Ingress, egress and local-command handshake bundle for
//                nx_msg_router.
//  Revision    : 1.0
// ============================================================================
interface nx_msg_router_if #(
    parameter int STREAM_WIDTH  = 32,
    parameter int COMMAND_WIDTH = 2,
    parameter int PAYLOAD_WIDTH = 21
);
    logic [STREAM_WIDTH-1:0]   msg_data_i;
    logic [1:0]                msg_dir_i;
    logic                      msg_valid_i;
    logic                      msg_ready_o;
    logic [4*STREAM_WIDTH-1:0] egr_data_o;
    logic [3:0]                egr_valid_o;
    logic [3:0]                egr_ready_i;
    logic [COMMAND_WIDTH-1:0]  lcl_command_o;
    logic [PAYLOAD_WIDTH-1:0]  lcl_payload_o;
    logic                      lcl_valid_o;
    logic                      lcl_ready_i;

    modport master (
        output msg_data_i, msg_dir_i, msg_valid_i, egr_ready_i, lcl_ready_i,
        input  msg_ready_o, egr_data_o, egr_valid_o, lcl_command_o, lcl_payload_o, lcl_valid_o
    );

    modport slave (
        input  msg_data_i, msg_dir_i, msg_valid_i, egr_ready_i, lcl_ready_i,
        output msg_ready_o, egr_data_o, egr_valid_o, lcl_command_o, lcl_payload_o, lcl_valid_o
    );
endinterface
`default_nettype wire

// File: rtl/nx_msg_router.sv
`default_nettype none
// ============================================================================
//  Module      : nx_msg_router
//  Description : Mesh-node message router: ingress FIFO, head decode, forked
//                dispatch to local port and four egress directions.
//  Revision    : 1.0
// ============================================================================
module nx_msg_router #(
    parameter int STREAM_WIDTH   = 32,
    parameter int ADDR_ROW_WIDTH = 4,
    parameter int ADDR_COL_WIDTH = 4,
    parameter int COMMAND_WIDTH  = 2,
    parameter int FIFO_DEPTH     = 2,
    parameter int COUNT_WIDTH    = 16
) (
    input  wire logic                      clk_i,
    input  wire logic                      rst_i,
    input  wire logic [ADDR_ROW_WIDTH-1:0] node_row_i,
    input  wire logic [ADDR_COL_WIDTH-1:0] node_col_i,
    nx_msg_router_if.slave                 bus,
    output logic [COUNT_WIDTH-1:0]         rx_count_o,
    output logic [COUNT_WIDTH-1:0]         tx_count_o
);
    localparam int PAYLOAD_WIDTH = STREAM_WIDTH - 1 - ADDR_ROW_WIDTH - ADDR_COL_WIDTH - COMMAND_WIDTH;
    localparam int DECAY_WIDTH   = ADDR_ROW_WIDTH + ADDR_COL_WIDTH;
    localparam int ROW_LSB       = STREAM_WIDTH - 1 - ADDR_ROW_WIDTH;
    localparam int COL_LSB       = ROW_LSB - ADDR_COL_WIDTH;
    localparam int ENTRY_WIDTH   = STREAM_WIDTH + 2;
    localparam int PTR_WIDTH     = $clog2(FIFO_DEPTH);
    localparam int CNT_WIDTH     = $clog2(FIFO_DEPTH + 1);
    localparam int SUM_WIDTH     = COUNT_WIDTH + 3;
    localparam logic [COUNT_WIDTH-1:0] c_cnt_max = '1;

    typedef enum logic [0:0] {
        IDLE     = 1'b0,
        DISPATCH = 1'b1
    } state_t;

    // ------------------------------------------------------------ ingress FIFO
    logic [ENTRY_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_WIDTH-1:0]   r_wr_ptr, r_rd_ptr;
    logic [CNT_WIDTH-1:0]   r_count, w_count_next;
    logic                   r_fresh;
    logic                   r_ready;
    logic [COUNT_WIDTH-1:0] r_rx_count, r_tx_count;
    logic                   w_push, w_avail, w_load;

    function automatic logic [PTR_WIDTH-1:0] f_next_ptr(input logic [PTR_WIDTH-1:0] p);
        return (p == PTR_WIDTH'(FIFO_DEPTH - 1)) ? '0 : p + PTR_WIDTH'(1);
    endfunction

    assign w_push = bus.msg_valid_i && r_ready;
    // The entry written at the previous edge is not yet poppable.
    assign w_avail = r_count > CNT_WIDTH'(r_fresh);

    always_comb begin
        w_count_next = r_count;
        if (w_push && !w_load)
            w_count_next = r_count + CNT_WIDTH'(1);
        else if (!w_push && w_load)
            w_count_next = r_count - CNT_WIDTH'(1);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_fresh    <= 1'b0;
            r_ready    <= 1'b0;
            r_rx_count <= '0;
        end else begin
            if (w_push) r_wr_ptr <= f_next_ptr(r_wr_ptr);
            if (w_load) r_rd_ptr <= f_next_ptr(r_rd_ptr);
            r_count <= w_count_next;
            r_fresh <= w_push;
            r_ready <= (w_count_next != CNT_WIDTH'(FIFO_DEPTH));
            if (w_push && (r_rx_count != c_cnt_max)) r_rx_count <= r_rx_count + COUNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push) r_mem[r_wr_ptr] <= {bus.msg_dir_i, bus.msg_data_i};
    end

    // ------------------------------------------------------------ head decode
    logic [ENTRY_WIDTH-1:0]    w_head;
    logic [STREAM_WIDTH-1:0]   w_msg, w_fwd;
    logic [1:0]                w_dir;
    logic [ADDR_ROW_WIDTH-1:0] w_row;
    logic [ADDR_COL_WIDTH-1:0] w_col;
    logic [DECAY_WIDTH-1:0]    w_decay;
    logic [4:0]                w_new_mask;

    assign w_head  = r_mem[r_rd_ptr];
    assign w_msg   = w_head[STREAM_WIDTH-1:0];
    assign w_dir   = w_head[ENTRY_WIDTH-1:STREAM_WIDTH];
    assign w_row   = w_msg[ROW_LSB +: ADDR_ROW_WIDTH];
    assign w_col   = w_msg[COL_LSB +: ADDR_COL_WIDTH];
    assign w_decay = w_msg[COL_LSB +: DECAY_WIDTH];

    always_comb begin
        w_new_mask = 5'b0;
        w_fwd      = w_msg;
        if (w_msg[STREAM_WIDTH-1]) begin
            w_new_mask[4] = 1'b1;
            if (w_decay != '0) begin
                case (w_dir)
                    2'd0:    w_new_mask[3:0] = 4'b1110;
                    2'd1:    w_new_mask[3:0] = 4'b1000;
                    2'd2:    w_new_mask[3:0] = 4'b1011;
                    default: w_new_mask[3:0] = 4'b0010;
                endcase
                w_fwd[COL_LSB +: DECAY_WIDTH] = w_decay - DECAY_WIDTH'(1);
            end
        end else if (w_row == node_row_i && w_col == node_col_i) begin
            w_new_mask = 5'b10000;
        end else if (w_row < node_row_i) begin
            w_new_mask = 5'b00001;
        end else if (w_row > node_row_i) begin
            w_new_mask = 5'b00100;
        end else if (w_col < node_col_i) begin
            w_new_mask = 5'b01000;
        end else begin
            w_new_mask = 5'b00010;
        end
    end

    // ------------------------------------------------------------ dispatch
    state_t                   r_state;
    logic [4:0]               r_mask;
    logic [STREAM_WIDTH-1:0]  r_fwd;
    logic [COMMAND_WIDTH-1:0] r_cmd;
    logic [PAYLOAD_WIDTH-1:0] r_payload;
    logic [4:0]               w_hs, w_mask_left;
    logic [2:0]               w_tx_inc;
    logic [SUM_WIDTH-1:0]     w_tx_sum;

    assign w_hs        = r_mask & {bus.lcl_ready_i, bus.egr_ready_i};
    assign w_mask_left = r_mask & ~w_hs;
    // A new head may load in the same cycle the last pending copy is taken.
    assign w_load      = w_avail && ((r_state == IDLE) || (w_mask_left == 5'b0));

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_state   <= IDLE;
            r_mask    <= 5'b0;
            r_fwd     <= '0;
            r_cmd     <= '0;
            r_payload <= '0;
        end else if (w_load) begin
            r_state   <= (w_new_mask != 5'b0) ? DISPATCH : IDLE;
            r_mask    <= w_new_mask;
            r_fwd     <= w_fwd;
            r_cmd     <= w_msg[PAYLOAD_WIDTH +: COMMAND_WIDTH];
            r_payload <= w_msg[PAYLOAD_WIDTH-1:0];
        end else begin
            r_state   <= (w_mask_left != 5'b0) ? DISPATCH : IDLE;
            r_mask    <= w_mask_left;
        end
    end

    // ------------------------------------------------------------ tx counter
    assign w_tx_inc = 3'(w_hs[0]) + 3'(w_hs[1]) + 3'(w_hs[2]) + 3'(w_hs[3]);
    assign w_tx_sum = {3'b000, r_tx_count} + SUM_WIDTH'(w_tx_inc);

    always_ff @(posedge clk_i) begin
        if (!rst_i)
            r_tx_count <= '0;
        else if (w_tx_sum > SUM_WIDTH'(c_cnt_max))
            r_tx_count <= c_cnt_max;
        else
            r_tx_count <= w_tx_sum[COUNT_WIDTH-1:0];
    end

    // ------------------------------------------------------------ outputs
    for (genvar gi = 0; gi < 4; gi++) begin : g_egr
        assign bus.egr_data_o[gi*STREAM_WIDTH +: STREAM_WIDTH] = r_fwd;
    end

    assign bus.egr_valid_o   = r_mask[3:0];
    assign bus.lcl_valid_o   = r_mask[4];
    assign bus.lcl_command_o = r_cmd;
    assign bus.lcl_payload_o = r_payload;
    assign bus.msg_ready_o   = r_ready;
    assign rx_count_o        = r_rx_count;
    assign tx_count_o        = r_tx_count;
endmodule
`default_nettype wire

// File: tb/tb_nx_msg_router.sv
`default_nettype none
// ============================================================================
//  Module      : tb_nx_msg_router
//  Description : Table-driven, scoreboard-checked bench for nx_msg_router.
//  Revision    : 1.0
// ============================================================================
module tb_nx_msg_router;
    localparam int SW  = 32;
    localparam int RW  = 4;
    localparam int CW  = 4;
    localparam int CMW = 2;
    localparam int PW  = SW - 1 - RW - CW - CMW;

    typedef struct {
        logic [SW-1:0] msg;
        logic [1:0]    dir;
        logic [4:0]    mask;
        logic [SW-1:0] fwd;
    } vec_t;

    typedef struct {
        logic [SW-1:0] msg;
        logic [SW-1:0] fwd;
        logic [4:0]    left;
    } sb_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  node_row = 4'd2;
    logic [3:0]  node_col = 4'd3;
    logic [15:0] rx_a, tx_a;
    logic [1:0]  rx_b, tx_b;
    int          n_checks = 0;
    int          n_errors = 0;
    int          n_rx = 0;
    int          n_tx = 0;
    int          cyc = 0;
    sb_t         sb[$];
    vec_t        tbl[11];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    nx_msg_router_if #(.STREAM_WIDTH(SW), .COMMAND_WIDTH(CMW), .PAYLOAD_WIDTH(PW)) bus_a();
    nx_msg_router_if #(.STREAM_WIDTH(SW), .COMMAND_WIDTH(CMW), .PAYLOAD_WIDTH(PW)) bus_b();

    nx_msg_router #(
        .STREAM_WIDTH(SW), .ADDR_ROW_WIDTH(RW), .ADDR_COL_WIDTH(CW),
        .COMMAND_WIDTH(CMW), .FIFO_DEPTH(3), .COUNT_WIDTH(16)
    ) dut_a (
        .clk_i(clk), .rst_i(rst_n), .node_row_i(node_row), .node_col_i(node_col),
        .bus(bus_a.slave), .rx_count_o(rx_a), .tx_count_o(tx_a)
    );

    nx_msg_router #(
        .STREAM_WIDTH(SW), .ADDR_ROW_WIDTH(RW), .ADDR_COL_WIDTH(CW),
        .COMMAND_WIDTH(CMW), .FIFO_DEPTH(2), .COUNT_WIDTH(2)
    ) dut_b (
        .clk_i(clk), .rst_i(rst_n), .node_row_i(node_row), .node_col_i(node_col),
        .bus(bus_b.slave), .rx_count_o(rx_b), .tx_count_o(tx_b)
    );

    assign bus_b.msg_data_i  = bus_a.msg_data_i;
    assign bus_b.msg_dir_i   = bus_a.msg_dir_i;
    assign bus_b.msg_valid_i = bus_a.msg_valid_i;
    assign bus_b.egr_ready_i = bus_a.egr_ready_i;
    assign bus_b.lcl_ready_i = bus_a.lcl_ready_i;

    function automatic logic [SW-1:0] mk(input logic b, input logic [3:0] r, input logic [3:0] c,
                                         input logic [1:0] cmd, input logic [PW-1:0] p);
        return {b, r, c, cmd, p};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Caller is always at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic push(input vec_t v);
        int  n;
        sb_t e;
        n = 0;
        bus_a.msg_data_i  = v.msg;
        bus_a.msg_dir_i   = v.dir;
        bus_a.msg_valid_i = 1'b1;
        while (!bus_a.msg_ready_o && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (!bus_a.msg_ready_o) begin
            chk("push_timeout", 64'(n), 64'd0);
        end else begin
            @(posedge clk); #1;
            e.msg  = v.msg;
            e.fwd  = v.fwd;
            e.left = v.mask;
            sb.push_back(e);
            n_rx++;
        end
        bus_a.msg_valid_i = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk("drain_done", 64'(sb.size()), 64'd0);
    endtask

    task automatic wait_valid(output int waited);
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (bus_a.egr_valid_o == 4'b0 && !bus_a.lcl_valid_o && waited < 20);
    endtask

    // Scoreboard monitor: sampled mid-cycle, handshakes complete at the next edge.
    always @(negedge clk) begin
        logic [4:0] vm, hs;
        if (rst_n) begin
            vm = {bus_a.lcl_valid_o, bus_a.egr_valid_o};
            hs = vm & {bus_a.lcl_ready_i, bus_a.egr_ready_i};
            if (vm != 5'b0) begin
                if (sb.size() == 0) begin
                    chk("unexpected_valid", 64'(vm), 64'd0);
                end else begin
                    chk("valid_mask", 64'(vm & ~sb[0].left), 64'd0);
                    for (int d = 0; d < 4; d++) begin
                        if (hs[d]) begin
                            chk("egr_data", 64'(bus_a.egr_data_o[d*SW +: SW]), 64'(sb[0].fwd));
                            n_tx++;
                        end
                    end
                    if (hs[4]) begin
                        chk("lcl_cmd", 64'(bus_a.lcl_command_o), 64'(sb[0].msg[PW +: CMW]));
                        chk("lcl_payload", 64'(bus_a.lcl_payload_o), 64'(sb[0].msg[PW-1:0]));
                    end
                    sb[0].left = sb[0].left & ~hs;
                    if (sb[0].left == 5'b0) void'(sb.pop_front());
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        int   w;
        int   acc;
        logic [15:0] tx_before;

        // Node (2,3). Expected masks {L,W,S,E,N} and forwarded copies derived by hand.
        tbl[0]  = '{mk(0, 4'd1, 4'd3,  2'd1, 21'h1ABCD), 2'd0, 5'b00001, mk(0, 4'd1, 4'd3,  2'd1, 21'h1ABCD)};
        tbl[1]  = '{mk(0, 4'd6, 4'd0,  2'd2, 21'h00055), 2'd1, 5'b00100, mk(0, 4'd6, 4'd0,  2'd2, 21'h00055)};
        tbl[2]  = '{mk(0, 4'd2, 4'd0,  2'd0, 21'h12345), 2'd2, 5'b01000, mk(0, 4'd2, 4'd0,  2'd0, 21'h12345)};
        tbl[3]  = '{mk(0, 4'd2, 4'd9,  2'd3, 21'h0F0F0), 2'd3, 5'b00010, mk(0, 4'd2, 4'd9,  2'd3, 21'h0F0F0)};
        tbl[4]  = '{mk(0, 4'd2, 4'd3,  2'd3, 21'h1FFFF), 2'd0, 5'b10000, mk(0, 4'd2, 4'd3,  2'd3, 21'h1FFFF)};
        tbl[5]  = '{mk(1, 4'h1, 4'h0,  2'd1, 21'h00777), 2'd0, 5'b11110, mk(1, 4'h0, 4'hF,  2'd1, 21'h00777)};
        tbl[6]  = '{mk(1, 4'hF, 4'hF,  2'd2, 21'h0AAAA), 2'd1, 5'b11000, mk(1, 4'hF, 4'hE,  2'd2, 21'h0AAAA)};
        tbl[7]  = '{mk(1, 4'h0, 4'h1,  2'd0, 21'h13579), 2'd3, 5'b10010, mk(1, 4'h0, 4'h0,  2'd0, 21'h13579)};
        tbl[8]  = '{mk(1, 4'h0, 4'h2,  2'd3, 21'h02468), 2'd2, 5'b11011, mk(1, 4'h0, 4'h1,  2'd3, 21'h02468)};
        tbl[9]  = '{mk(0, 4'd0, 4'd15, 2'd1, 21'h11111), 2'd1, 5'b00001, mk(0, 4'd0, 4'd15, 2'd1, 21'h11111)};
        tbl[10] = '{mk(0, 4'd9, 4'd1,  2'd0, 21'h00001), 2'd2, 5'b00100, mk(0, 4'd9, 4'd1,  2'd0, 21'h00001)};

        // Reset held with a valid message offered.
        bus_a.msg_data_i  = tbl[0].msg;
        bus_a.msg_dir_i   = 2'd0;
        bus_a.msg_valid_i = 1'b1;
        bus_a.egr_ready_i = 4'b1111;
        bus_a.lcl_ready_i = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_egr_valid", 64'(bus_a.egr_valid_o), 64'd0);
        chk("rst_lcl_valid", 64'(bus_a.lcl_valid_o), 64'd0);
        chk("rst_rx", 64'(rx_a), 64'd0);
        chk("rst_tx", 64'(tx_a), 64'd0);
        chk("rst_egr_data", 64'(bus_a.egr_data_o[SW-1:0]), 64'd0);
        rst_n = 1'b1;
        bus_a.msg_valid_i = 1'b0;
        @(posedge clk); #1;
        chk("rst_ready_after_release", 64'(bus_a.msg_ready_o), 64'd1);
        chk("rst_no_push", 64'(rx_a), 64'd0);

        // Unicast latency: accept at edge T, valid visible after edge T+2.
        v = '{mk(0, 4'd1, 4'd3, 2'd2, 21'h0BEEF), 2'd1, 5'b00001, mk(0, 4'd1, 4'd3, 2'd2, 21'h0BEEF)};
        push(v);
        acc = cyc;
        wait_valid(w);
        chk("uni_latency", 64'(cyc - acc), 64'd2);
        chk("uni_valid_n", 64'(bus_a.egr_valid_o), 64'b0001);
        chk("uni_lcl_idle", 64'(bus_a.lcl_valid_o), 64'd0);
        @(posedge clk); #1;
        drain();

        // Back-to-back table with all ready high.
        for (int i = 0; i < 11; i++) push(tbl[i]);
        drain();
        chk("table_rx", 64'(rx_a), 64'(n_rx));
        chk("table_tx", 64'(tx_a), 64'(n_tx));
        chk("sat_rx_b", 64'(rx_b), 64'd3);

        // Broadcast decay 02 from S; W held off for three cycles, local msg queued behind.
        bus_a.egr_ready_i = 4'b0011;
        push(tbl[8]);
        v = '{mk(0, 4'd2, 4'd3, 2'd1, 21'h00042), 2'd0, 5'b10000, mk(0, 4'd2, 4'd3, 2'd1, 21'h00042)};
        push(v);
        wait_valid(w);
        chk("bc_first_valid", 64'({bus_a.lcl_valid_o, bus_a.egr_valid_o}), 64'b11011);
        chk("bc_decay_fwd", 64'(bus_a.egr_data_o[3*SW +: SW]), 64'(tbl[8].fwd));
        @(negedge clk);
        chk("bc_w_wait1", 64'({bus_a.lcl_valid_o, bus_a.egr_valid_o}), 64'b01000);
        @(negedge clk);
        chk("bc_w_wait2", 64'({bus_a.lcl_valid_o, bus_a.egr_valid_o}), 64'b01000);
        @(posedge clk); #1;
        bus_a.egr_ready_i = 4'b1011;
        @(negedge clk);
        chk("bc_w_last", 64'({bus_a.lcl_valid_o, bus_a.egr_valid_o}), 64'b01000);
        @(negedge clk);
        chk("bc_next_load", 64'({bus_a.lcl_valid_o, bus_a.egr_valid_o}), 64'b10000);
        @(posedge clk); #1;
        bus_a.egr_ready_i = 4'b1111;
        drain();

        // Broadcast with zero decay: local only, tx unchanged.
        tx_before = tx_a;
        v = '{mk(1, 4'h0, 4'h0, 2'd1, 21'h00321), 2'd0, 5'b10000, mk(1, 4'h0, 4'h0, 2'd1, 21'h00321)};
        push(v);
        drain();
        chk("bc_decay0_tx", 64'(tx_a), 64'(tx_before));
        chk("sat_rx_b_hold", 64'(rx_b), 64'd3);

        // Reset while messages are held and buffered.
        bus_a.egr_ready_i = 4'b0000;
        bus_a.lcl_ready_i = 1'b0;
        push(tbl[0]);
        push(tbl[1]);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        sb.delete();
        n_rx = 0;
        n_tx = 0;
        chk("midrst_egr_valid", 64'(bus_a.egr_valid_o), 64'd0);
        chk("midrst_rx", 64'(rx_a), 64'd0);
        chk("midrst_rx_b", 64'(rx_b), 64'd0);
        rst_n = 1'b1;
        bus_a.egr_ready_i = 4'b1111;
        bus_a.lcl_ready_i = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("midrst_no_output", 64'({bus_a.lcl_valid_o, bus_a.egr_valid_o}), 64'd0);
        chk("midrst_tx", 64'(tx_a), 64'd0);

        // FIFO_DEPTH=3 fill with everything stalled: 1 held + 3 buffered.
        bus_a.egr_ready_i = 4'b0000;
        bus_a.lcl_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) push(tbl[i]);
        chk("fill_ready_after3", 64'(bus_a.msg_ready_o), 64'd1);
        push(tbl[3]);
        chk("fill_ready_after4", 64'(bus_a.msg_ready_o), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("fill_ready_hold", 64'(bus_a.msg_ready_o), 64'd0);
        chk("fill_rx", 64'(rx_a), 64'd4);
        bus_a.egr_ready_i = 4'b1111;
        bus_a.lcl_ready_i = 1'b1;
        drain();
        chk("fill_rx_final", 64'(rx_a), 64'd4);
        chk("fill_tx", 64'(tx_a), 64'(n_tx));

        // Second pass over the table after the fill/drain.
        for (int i = 0; i < 11; i++) push(tbl[i]);
        drain();
        chk("final_rx", 64'(rx_a), 64'(n_rx));
        chk("final_tx", 64'(tx_a), 64'(n_tx));
        chk("final_rx_b", 64'(rx_b), 64'd3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire
